// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the round/saturate helper used by the
// twiddle rotation multiplier.
package fft_pkg;

  localparam int DATA_W    = 32'd16;
  localparam int TW_W      = 32'd18;
  localparam int TW_FRAC   = 32'd16;
  localparam int TW_LAT    = 32'd2;
  localparam int FRAME_LEN = 32'd16;
  localparam int TW_ONE    = 32'd1 << TW_FRAC;

  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int PROD_W = DATA_W + TW_W;
  localparam int SUM_W  = PROD_W + 32'd1;
  localparam int SHR_W  = SUM_W - TW_FRAC;

  typedef struct packed {
    logic                     sat;
    logic signed [DATA_W-1:0] val;
  } rs_t;

  localparam logic signed [SUM_W-1:0] ROUND_HALF =
    {{(SUM_W-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};
  localparam logic signed [SHR_W-1:0] SAT_MAX =
    {{(SHR_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SHR_W-1:0] SAT_MIN =
    {{(SHR_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Round half toward +inf, drop the fractional bits, clip to the sample range.
  function automatic rs_t round_sat(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] r;
    logic signed [SHR_W-1:0] s;
    rs_t                     res;
    r = x + ROUND_HALF;
    s = r[SUM_W-1:TW_FRAC];
    if (s > SAT_MAX) begin
      res.sat = 1'b1;
      res.val = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (s < SAT_MIN) begin
      res.sat = 1'b1;
      res.val = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res.sat = 1'b0;
      res.val = s[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cmult_pipe.sv
// Three-stage pipelined complex multiplier (products, sum/difference,
// round+saturate) with a valid/last tag carried alongside the data.
module cmult_pipe
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [TW_W-1:0]   b_re,
  input  logic signed [TW_W-1:0]   b_im,
  output logic                     out_valid,
  output logic                     out_last,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_sat
);

  logic signed [PROD_W-1:0] rr_d, ii_d, ri_d, ir_d, rr_q, ii_q, ri_q, ir_q;
  logic signed [SUM_W-1:0]  re_d, im_d, re_q, im_q;
  logic signed [DATA_W-1:0] o_re_d, o_im_d, o_re_q, o_im_q;
  logic                     o_sat_d, o_sat_q;
  logic [2:0]               vld_d, vld_q, lst_d, lst_q;
  rs_t                      rs_re_s, rs_im_s;

  always_comb begin
    rr_d = PROD_W'(a_re) * PROD_W'(b_re);
    ii_d = PROD_W'(a_im) * PROD_W'(b_im);
    ri_d = PROD_W'(a_re) * PROD_W'(b_im);
    ir_d = PROD_W'(a_im) * PROD_W'(b_re);

    re_d = SUM_W'(rr_q) - SUM_W'(ii_q);
    im_d = SUM_W'(ri_q) + SUM_W'(ir_q);

    rs_re_s = round_sat(re_q);
    rs_im_s = round_sat(im_q);
    o_re_d  = rs_re_s.val;
    o_im_d  = rs_im_s.val;
    o_sat_d = rs_re_s.sat | rs_im_s.sat;

    vld_d = {vld_q[1:0], in_valid};
    lst_d = {lst_q[1:0], in_last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= '0;
      ii_q    <= '0;
      ri_q    <= '0;
      ir_q    <= '0;
      re_q    <= '0;
      im_q    <= '0;
      o_re_q  <= '0;
      o_im_q  <= '0;
      o_sat_q <= 1'b0;
      vld_q   <= 3'b000;
      lst_q   <= 3'b000;
    end else begin
      rr_q    <= rr_d;
      ii_q    <= ii_d;
      ri_q    <= ri_d;
      ir_q    <= ir_d;
      re_q    <= re_d;
      im_q    <= im_d;
      o_re_q  <= o_re_d;
      o_im_q  <= o_im_d;
      o_sat_q <= o_sat_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
    end
  end

  assign out_valid = vld_q[2];
  assign out_last  = lst_q[2] & vld_q[2];
  assign out_re    = o_re_q;
  assign out_im    = o_im_q;
  assign out_sat   = o_sat_q;

endmodule

// File: rtl/twiddle_rotate.sv
// Rotates a burst of samples by generator twiddles: aligns each sample with
// its twiddle, tracks frame position, and flags bursts that end mid-frame.
module twiddle_rotate
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_img,
  output logic                     tw_req,
  input  logic signed [TW_W-1:0]   tw_real,
  input  logic signed [TW_W-1:0]   tw_img,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_img,
  output logic                     out_last,
  output logic                     out_sat,
  output logic                     frame_err
);

  logic [IDX_W-1:0]         idx_d, idx_q;
  logic                     frame_err_d, frame_err_q;
  logic                     last_s;
  logic                     al_valid_d [TW_LAT];
  logic                     al_valid_q [TW_LAT];
  logic                     al_last_d  [TW_LAT];
  logic                     al_last_q  [TW_LAT];
  logic signed [DATA_W-1:0] al_re_d    [TW_LAT];
  logic signed [DATA_W-1:0] al_re_q    [TW_LAT];
  logic signed [DATA_W-1:0] al_im_d    [TW_LAT];
  logic signed [DATA_W-1:0] al_im_q    [TW_LAT];

  // The generator's address follows tw_req, so it must be low during reset.
  assign tw_req = in_valid & ~rst;

  always_comb begin
    idx_d       = idx_q;
    frame_err_d = frame_err_q;
    last_s      = 1'b0;
    if (in_valid) begin
      last_s = (idx_q == IDX_W'(FRAME_LEN - 1));
      idx_d  = idx_q + IDX_W'(1);
    end else begin
      idx_d = '0;
      if (idx_q != '0) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = frame_err_q;
      end
    end

    al_valid_d[0] = in_valid;
    al_last_d[0]  = last_s;
    al_re_d[0]    = in_real;
    al_im_d[0]    = in_img;
    for (int i = 1; i < TW_LAT; i++) begin
      al_valid_d[i] = al_valid_q[i-1];
      al_last_d[i]  = al_last_q[i-1];
      al_re_d[i]    = al_re_q[i-1];
      al_im_d[i]    = al_im_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < TW_LAT; i++) begin
        al_valid_q[i] <= 1'b0;
        al_last_q[i]  <= 1'b0;
        al_re_q[i]    <= '0;
        al_im_q[i]    <= '0;
      end
    end else begin
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < TW_LAT; i++) begin
        al_valid_q[i] <= al_valid_d[i];
        al_last_q[i]  <= al_last_d[i];
        al_re_q[i]    <= al_re_d[i];
        al_im_q[i]    <= al_im_d[i];
      end
    end
  end

  cmult_pipe u_cmult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (al_valid_q[TW_LAT-1]),
    .in_last   (al_last_q[TW_LAT-1]),
    .a_re      (al_re_q[TW_LAT-1]),
    .a_im      (al_im_q[TW_LAT-1]),
    .b_re      (tw_real),
    .b_im      (tw_img),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_re    (out_real),
    .out_im    (out_img),
    .out_sat   (out_sat)
  );

  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_twiddle_rotate.sv
// Scoreboard bench for twiddle_rotate with a behavioural twiddle generator.
module tb_twiddle_rotate;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_real, in_img;
  logic               tw_req;
  logic signed [17:0] tw_real, tw_img;
  logic               out_valid, out_last, out_sat, frame_err;
  logic signed [15:0] out_real, out_img;

  typedef struct {
    longint re;
    longint im;
    bit     last;
    bit     sat;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  int     burst_k  = 0;
  int     fidx     = 0;

  logic signed [17:0] tab_re [16];
  logic signed [17:0] tab_im [16];
  logic [3:0]         gen_addr = 4'd0;
  logic signed [17:0] g0_re = 18'sd0, g0_im = 18'sd0, g1_re = 18'sd0, g1_im = 18'sd0;

  twiddle_rotate dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real), .in_img(in_img),
    .tw_req(tw_req), .tw_real(tw_real), .tw_img(tw_img), .out_valid(out_valid),
    .out_real(out_real), .out_img(out_img), .out_last(out_last), .out_sat(out_sat),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Twiddle generator: address advances on tw_req, clears when idle, 2-cycle latency.
  always @(posedge clk) begin
    if (tw_req) begin
      g0_re    <= tab_re[gen_addr];
      g0_im    <= tab_im[gen_addr];
      gen_addr <= gen_addr + 4'd1;
    end else begin
      g0_re    <= 18'sd0;
      g0_im    <= 18'sd0;
      gen_addr <= 4'd0;
    end
    g1_re <= g0_re;
    g1_im <= g0_im;
  end
  assign tw_real = g1_re;
  assign tw_img  = g1_im;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("out_real", out_real, e.re);
        check_val("out_img", out_img, e.im);
        check_val("out_last", out_last, e.last);
        check_val("out_sat", out_sat, e.sat);
        check_val("latency", cyc - e.cyc, 5);
      end
    end
  end

  function automatic longint clip(input longint v, output bit s);
    longint r;
    r = (v + 32768) >>> 16;
    s = 1'b0;
    if (r > 32767) begin r = 32767; s = 1'b1; end
    if (r < -32768) begin r = -32768; s = 1'b1; end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] re, input logic signed [15:0] im);
    exp_t   e;
    longint tr, ti, xr, xi;
    bit     s1, s2;
    tr = tab_re[burst_k % 16];
    ti = tab_im[burst_k % 16];
    xr = longint'(re) * tr - longint'(im) * ti;
    xi = longint'(re) * ti + longint'(im) * tr;
    e.re   = clip(xr, s1);
    e.im   = clip(xi, s2);
    e.sat  = s1 | s2;
    e.last = (fidx == 15);
    e.cyc  = cyc;
    sb.push_back(e);
    fidx    = (fidx + 1) % 16;
    burst_k = burst_k + 1;
    in_valid = 1'b1;
    in_real  = re;
    in_img   = im;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_real  = 16'sd0;
    in_img   = 16'sd0;
    burst_k  = 0;
    fidx     = 0;
    repeat (n) tick();
  endtask

  task automatic drain(input string tag);
    idle(8);
    check_val(tag, sb.size(), 0);
  endtask

  task automatic rand_table();
    for (int i = 0; i < 16; i++) begin
      tab_re[i] = 18'($signed($urandom_range(0, 131072)) - 65536);
      tab_im[i] = 18'($signed($urandom_range(0, 131072)) - 65536);
    end
  endtask

  task automatic rand_burst(input int n);
    for (int i = 0; i < n; i++) send(16'($urandom), 16'($urandom));
    idle(1);
  endtask

  task automatic single(input logic signed [17:0] tr, input logic signed [17:0] ti,
                        input logic signed [15:0] re, input logic signed [15:0] im);
    tab_re[0] = tr;
    tab_im[0] = ti;
    send(re, im);
    idle(1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_valid"}, out_valid, 0);
    check_val({tag, "_last"}, out_last, 0);
    check_val({tag, "_sat"}, out_sat, 0);
    check_val({tag, "_err"}, frame_err, 0);
    check_val({tag, "_real"}, out_real, 0);
    check_val({tag, "_img"}, out_img, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_real = 16'sd0; in_img = 16'sd0;
    for (int i = 0; i < 16; i++) begin tab_re[i] = 18'sd0; tab_im[i] = 18'sd0; end
    repeat (3) tick();
    in_valid = 1'b1;
    #1;
    check_val("tw_req_in_rst", tw_req, 0);
    in_valid = 1'b0;
    check_zero_outputs("rst");
    tick();
    rst = 1'b0;
    idle(2);

    // Two back-to-back frames, then two frames with a one-cycle gap.
    rand_table();
    rand_burst(32);
    drain("drain_32");
    check_val("err_after_32", frame_err, 0);
    rand_burst(16);
    rand_burst(16);
    drain("drain_gap");
    check_val("err_after_gap", frame_err, 0);

    // Directed arithmetic cases, each a single-sample burst at twiddle index 0.
    tab_re[0] = 18'sd65536; tab_im[0] = 18'sd0;
    in_valid = 1'b1; in_real = 16'sd1000; in_img = -16'sd2000;
    #1;
    check_val("tw_req_follow", tw_req, 1);
    send(16'sd1000, -16'sd2000);
    idle(1);
    single(18'sd0, -18'sd65536, 16'sd1000, -16'sd2000);
    single(18'sd46341, -18'sd46341, 16'sd32767, 16'sd32767);
    single(18'sd32768, 18'sd0, 16'sd1, 16'sd0);
    single(18'sd32768, 18'sd0, -16'sd1, 16'sd0);
    single(18'sd32768, 18'sd0, 16'sd3, 16'sd0);
    single(18'sd65536, 18'sd0, -16'sd32768, -16'sd32768);
    drain("drain_directed");

    // Short burst sets a sticky error that only rst clears.
    rst = 1'b1; tick(); rst = 1'b0; idle(1);
    check_val("err_cleared", frame_err, 0);
    rand_table();
    rand_burst(7);
    drain("drain_short");
    check_val("err_short", frame_err, 1);
    rand_burst(16);
    drain("drain_after_short");
    check_val("err_sticky", frame_err, 1);

    // Reset mid-burst discards in-flight samples.
    rst = 1'b1; tick(); rst = 1'b0; idle(1);
    rand_burst(0);
    send(16'sd100, 16'sd200);
    send(16'sd300, 16'sd400);
    send(16'sd500, 16'sd600);
    rst = 1'b1; in_valid = 1'b1;
    sb.delete();
    burst_k = 0; fidx = 0;
    #1;
    check_zero_outputs("mid_rst");
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_val("flushed", out_valid, 0);
    end
    #1;
    idle(1);
    rand_table();
    rand_burst(16);
    drain("drain_after_rst");
    check_val("err_after_rst", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", cyc, 0);
    $fatal(1);
  end

endmodule
